// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side streaming logic: drainer FSM states and
// the legal range for the prefetch buffer depth.
package fifo_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2
  } rd_state_e;

  localparam int unsigned BUF_DEPTH_MIN = 2;
  localparam int unsigned BUF_DEPTH_MAX = 4;

  function automatic bit buf_depth_legal(int unsigned depth);
    return (depth >= BUF_DEPTH_MIN) && (depth <= BUF_DEPTH_MAX);
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Small circular prefetch buffer with push/pop/clear. The head entry is presented
// combinationally; clear takes priority over push and pop in the same cycle.
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_clear,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_occ
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;

  logic [WIDTH-1:0] r_mem [DEPTH];
  ptr_t             r_head;
  ptr_t             r_tail;
  logic [OCC_W-1:0] r_occ;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      r_mem  <= '{default: '0};
    end else if (i_clear) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_data;
        r_tail        <= ptr_inc(r_tail);
      end
      if (i_pop) begin
        r_head <= ptr_inc(r_head);
      end
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_data = r_mem[r_head];
  assign o_occ  = r_occ;

  a_depth_legal: assert property (@(posedge i_clk) buf_depth_legal(DEPTH));

  a_no_overrun: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && !i_pop && !i_clear && (r_occ == OCC_W'(DEPTH))));

  a_no_underrun: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_pop && !i_clear && (r_occ == '0)));

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side drainer: issues credit-limited reads, captures data one cycle later
// into a prefetch buffer and presents it as a valid/ready stream.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_rd,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 flush,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_rdata,
  input  logic                 fifo_underflow,
  output logic                 rd_en,
  output logic                 m_valid,
  output logic [WIDTH-1:0]     m_data,
  input  logic                 m_ready,
  output logic [CNT_WIDTH-1:0] beat_cnt,
  output logic                 err_underflow,
  output logic                 busy
);

  localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);

  typedef logic [OCC_W:0] used_t;

  rd_state_e            r_state;
  logic                 r_inflight;
  logic [CNT_WIDTH-1:0] r_beat_cnt;
  logic                 r_err;

  logic [OCC_W-1:0]     w_occ;
  logic [WIDTH-1:0]     w_head;
  logic                 w_pop;
  logic                 w_push;
  used_t                w_used;
  logic                 w_has_credit;

  // Credit counts words already buffered plus the one on its way, less the one leaving now.
  always_comb begin
    w_pop        = (w_occ != '0) && m_ready;
    w_used       = used_t'(w_occ) + used_t'(r_inflight) - used_t'(w_pop);
    w_has_credit = w_used < used_t'(BUF_DEPTH);
    w_push       = r_inflight && (r_state != StFlush) && !flush;
    rd_en        = rst_n && (r_state == StRun) && enable && !flush && !fifo_empty &&
                   w_has_credit;
  end

  always_ff @(posedge clk_rd) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_inflight <= 1'b0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_inflight <= rd_en;
      if (w_pop) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if (fifo_underflow) begin
        r_err <= 1'b1;
      end
      if (flush) begin
        r_state <= StFlush;
      end else begin
        case (r_state)
          StIdle:  if (enable) r_state <= StRun;
          StRun:   if (!enable && !r_inflight) r_state <= StIdle;
          StFlush: r_state <= StIdle;
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  stream_skid_buf #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .i_clk   (clk_rd),
    .i_rst_n (rst_n),
    .i_clear (flush),
    .i_push  (w_push),
    .i_data  (fifo_rdata),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_occ   (w_occ)
  );

  always_comb begin
    m_valid       = (w_occ != '0);
    m_data        = w_head;
    beat_cnt      = r_beat_cnt;
    err_underflow = r_err;
    busy          = (r_state != StIdle) || (w_occ != '0);
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based source FIFO, queue-level reference model checked
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_fifo_rd_stream;

  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 4;

  logic             clk_rd = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             flush;
  logic             fifo_empty;
  logic [W-1:0]     fifo_rdata;
  logic             fifo_underflow;
  logic             rd_en;
  logic             m_valid;
  logic [W-1:0]     m_data;
  logic             m_ready;
  logic [CNT_W-1:0] beat_cnt;
  logic             err_underflow;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_rd_stream #(
    .WIDTH     (W),
    .BUF_DEPTH (DEPTH),
    .CNT_WIDTH (CNT_W)
  ) dut (
    .clk_rd         (clk_rd),
    .rst_n          (rst_n),
    .enable         (enable),
    .flush          (flush),
    .fifo_empty     (fifo_empty),
    .fifo_rdata     (fifo_rdata),
    .fifo_underflow (fifo_underflow),
    .rd_en          (rd_en),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_ready        (m_ready),
    .beat_cnt       (beat_cnt),
    .err_underflow  (err_underflow),
    .busy           (busy)
  );

  always #5 clk_rd = ~clk_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source FIFO: words read on a rd_en cycle appear on fifo_rdata the next cycle.
  logic [W-1:0] src_q[$];
  logic [W-1:0] pend = '0;

  always @(negedge clk_rd) begin
    if (rd_en === 1'b1 && src_q.size() != 0) pend = src_q.pop_front();
  end

  task automatic tick();
    @(posedge clk_rd);
    #1;
    fifo_rdata = pend;
    fifo_empty = (src_q.size() == 0);
  endtask

  // Reference model: buffer contents as a queue, one in-flight flag, state as 0/1/2.
  logic [W-1:0]     mq[$];
  int               m_st = 0;
  bit               m_infl = 1'b0;
  logic [CNT_W-1:0] m_beat = '0;
  bit               m_err = 1'b0;
  bit               started = 1'b0;

  always @(negedge clk_rd) begin
    bit ev, pop, erd;
    ev  = (mq.size() != 0);
    pop = ev && (m_ready === 1'b1);
    erd = rst_n && (m_st == 1) && enable && !flush && !fifo_empty &&
          ((mq.size() + int'(m_infl) - int'(pop)) < int'(DEPTH));
    if (started) begin
      chk("rd_en", rd_en, erd);
      chk("m_valid", m_valid, ev);
      if (ev) chk("m_data", m_data, mq[0]);
      chk("beat_cnt", beat_cnt, m_beat);
      chk("err_underflow", err_underflow, m_err);
      chk("busy", busy, (m_st != 0) || ev);
    end
    if (!rst_n) begin
      mq.delete();
      m_st    = 0;
      m_infl  = 1'b0;
      m_beat  = '0;
      m_err   = 1'b0;
      started = 1'b1;
    end else if (started) begin
      if (pop) m_beat = m_beat + 1'b1;
      if (fifo_underflow) m_err = 1'b1;
      if (flush) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (m_infl && m_st != 2) mq.push_back(fifo_rdata);
      end
      m_infl = erd;
      if (flush) m_st = 2;
      else if (m_st == 0) m_st = enable ? 1 : 0;
      else if (m_st == 1) m_st = (!enable && !m_infl_prev(erd)) ? 0 : 1;
      else m_st = 0;
    end
  end

  // RUN leaves only when nothing was in flight during the cycle just evaluated.
  bit infl_seen = 1'b0;
  function automatic bit m_infl_prev(input bit unused_erd);
    return infl_seen;
  endfunction
  always @(posedge clk_rd) infl_seen <= m_infl;

  logic         rd_log [0:6];
  logic         v_log  [0:6];
  logic [W-1:0] d_log  [0:6];
  logic [CNT_W-1:0] b_log [0:6];
  logic [W-1:0] got[$];
  int           cnt;
  bit           flag;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; m_ready = 1'b0;
    fifo_underflow = 1'b0; fifo_empty = 1'b1; fifo_rdata = '0;
    repeat (3) tick();
    @(negedge clk_rd);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_beat", beat_cnt, 0);
    chk("rst_err", err_underflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", rd_en, 0);

    // Basic drain of three preloaded words.
    src_q.push_back(8'h11); src_q.push_back(8'h22); src_q.push_back(8'h33);
    tick();
    rst_n = 1'b1; enable = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick();
      @(negedge clk_rd);
      rd_log[c] = rd_en; v_log[c] = m_valid; d_log[c] = m_data; b_log[c] = beat_cnt;
    end
    chk("t1_rd0", rd_log[0], 1); chk("t1_rd1", rd_log[1], 1);
    chk("t1_rd2", rd_log[2], 1); chk("t1_rd3", rd_log[3], 0);
    chk("t1_v1", v_log[1], 0);
    chk("t1_v2", v_log[2], 1); chk("t1_d2", d_log[2], 8'h11);
    chk("t1_v3", v_log[3], 1); chk("t1_d3", d_log[3], 8'h22);
    chk("t1_v4", v_log[4], 1); chk("t1_d4", d_log[4], 8'h33);
    chk("t1_beat", b_log[5], 3); chk("t1_rd6", rd_log[6], 0);

    // Back-pressure with six words waiting.
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) src_q.push_back(8'hA0 + 8'(i));
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clk_rd);
      cnt += int'(rd_en);
      if (m_valid) chk("bp_hold", m_data, 8'hA0);
    end
    chk("bp_rd_cnt", cnt, 2);
    tick();
    m_ready = 1'b1;
    got.delete();
    for (int k = 0; k < 30 && got.size() < 6; k++) begin
      @(negedge clk_rd);
      if (m_valid && m_ready) got.push_back(m_data);
      tick();
    end
    chk("bp_count", got.size(), 6);
    for (int i = 0; i < got.size(); i++) chk("bp_order", got[i], 8'hA0 + 8'(i));

    // Empty FIFO, then one late word.
    cnt = 0; flag = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_rd);
      cnt += int'(rd_en);
      flag |= m_valid;
      tick();
    end
    chk("empty_rd", cnt, 0);
    chk("empty_valid", flag, 0);
    chk("empty_err", err_underflow, 0);
    src_q.push_back(8'h5A);
    flag = 1'b0;
    for (int k = 0; k < 10 && !flag; k++) begin
      tick();
      @(negedge clk_rd);
      if (rd_en) flag = 1'b1;
    end
    chk("late_rd_seen", flag, 1);
    tick(); @(negedge clk_rd);
    chk("late_v_n1", m_valid, 0);
    tick(); @(negedge clk_rd);
    chk("late_v_n2", m_valid, 1);
    chk("late_d_n2", m_data, 8'h5A);

    // Flush with one buffered and one in-flight word.
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) src_q.push_back(8'hC0 + 8'(i));
    tick(); tick(); tick();
    flush = 1'b1;
    @(negedge clk_rd);
    chk("fl_pre_valid", m_valid, 1);
    chk("fl_pre_busy", busy, 1);
    chk("fl_pre_beat", beat_cnt, 10);
    tick();
    flush = 1'b0; enable = 1'b0;
    @(negedge clk_rd);
    chk("fl_n1_valid", m_valid, 0);
    chk("fl_n1_rd", rd_en, 0);
    tick();
    src_q.delete();
    @(negedge clk_rd);
    chk("fl_n2_valid", m_valid, 0);
    chk("fl_n2_busy", busy, 0);
    chk("fl_n2_beat", beat_cnt, 10);

    // Sticky underflow error.
    tick();
    fifo_underflow = 1'b1;
    tick();
    fifo_underflow = 1'b0;
    @(negedge clk_rd);
    chk("uf_set", err_underflow, 1);
    repeat (3) tick();
    @(negedge clk_rd);
    chk("uf_sticky", err_underflow, 1);

    // Reset while streaming.
    tick();
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 10; i++) src_q.push_back(8'hE0 + 8'(i));
    got.delete();
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk_rd);
      if (m_valid && m_ready) got.push_back(m_data);
    end
    chk("rs_count", got.size(), 4);
    for (int i = 0; i < got.size(); i++) chk("rs_order", got[i], 8'hE0 + 8'(i));
    tick();
    rst_n = 1'b0;
    @(negedge clk_rd);
    chk("rs_rd_gate", rd_en, 0);
    tick();
    rst_n = 1'b1;
    src_q.delete();
    @(negedge clk_rd);
    chk("rs_valid", m_valid, 0);
    chk("rs_beat", beat_cnt, 0);
    chk("rs_err", err_underflow, 0);
    chk("rs_rd", rd_en, 0);
    flag = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk_rd);
      flag |= m_valid;
    end
    chk("rs_no_stale", flag, 0);

    // Randomized traffic; the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst_n          = ($urandom_range(0, 199) != 0);
      flush          = ($urandom_range(0, 39) == 0);
      enable         = ($urandom_range(0, 9) != 0);
      m_ready        = ($urandom_range(0, 9) < 6);
      fifo_underflow = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 1) == 1 && src_q.size() < 16) src_q.push_back(8'($urandom));
    end
    tick();
    @(negedge clk_rd);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
